dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Two-requester arbiter and sequencer for the single 256-bit data memory port (14-bit word address, 32-bit byte enable, registered-address RAM). It sits between the vector load/store unit and the data memory, and shares the port with a second master (host loader / debug DMA). Arbitration is round-robin with an optional bounded lock for bursts. Read data is returned to the issuing requester with a tagged valid pulse at fixed latency.

## Interface
Parameters:
- ADDR_W, 14, memory word address width
- DATA_W, 256, data width
- BE_W, 32, byte-enable width (DATA_W/8)
- READ_LATENCY, 1, cycles from accepted read to mem_readdata valid (legal 1..3)
- MAX_BURST, 8, maximum cycles a requester may hold a lock (legal 2..15)

Ports (n = 0, 1; port 0 is the vector load/store unit, port 1 the host/debug master):
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_n  in  1  requester n has a valid transaction
- lock_n  in  1  requester n asks to keep the port after this transfer
- we_n  in  1  1 = write, 0 = read
- addr_n  in  ADDR_W  word address
- be_n  in  BE_W  byte enables (writes only)
- wdata_n  in  DATA_W  write data
- gnt_n  out  1  transfer accepted this cycle when req_n & gnt_n
- rvalid_n  out  1  one-cycle pulse: rdata_n holds read data for requester n
- rdata_n  out  DATA_W  read data (mem_readdata broadcast, qualified by rvalid_n)
- mem_address  out  ADDR_W  to RAM
- mem_byteena  out  BE_W  to RAM
- mem_wren  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_readdata  in  DATA_W  from RAM
- busy  out  1  lock held or read in flight

## Operation
- State register: IDLE, LOCK0, LOCK1. Also last_winner (1 bit), burst_cnt (4 bit), tag pipe of READ_LATENCY entries {valid, id}.
- gnt is combinational from state and req; at most one gnt high per cycle; gnt_n never high without req_n.
- IDLE: only one req high -> grant it. Both high -> grant the port that is not last_winner. Neither -> no grant.
- On any transfer: last_winner <= granted id. If lock of the granted port = 1, go to LOCKn with burst_cnt <= 1.
- LOCKn: gnt_n = req_n; the other gnt = 0. burst_cnt increments every cycle in LOCKn, whether or not a transfer occurs.
- LOCKn exits to IDLE after any cycle in which (lock_n = 0) or (burst_cnt = MAX_BURST-1). The transfer in that cycle, if any, is still accepted. After a forced exit last_winner = n, so a waiting other port wins the next tie.
- Memory side, transfer cycle: mem_* = granted port fields; mem_wren = we. No transfer: mem_wren = 0, mem_byteena = 0, mem_address/mem_writedata = port 0 fields.
- Read transfer pushes {1, id} into the tag pipe; writes push {0, x}. At pipe output valid -> rvalid_id = 1 for one cycle. rdata0 = rdata1 = mem_readdata always.
- busy = (state != IDLE) | any tag valid.

## Timing
- Reset (reset = 0, asynchronous): state IDLE, last_winner = 1 (port 0 wins first tie), burst_cnt = 0, tag pipe cleared. rvalid_n = 0, busy = 0, mem_wren = 0, mem_byteena = 0. gnt follows req combinationally.
- Reset mid-operation: in-flight read tags discarded. No rvalid after release. Lock released.
- Throughput: one transfer per cycle; back-to-back grants to the same port allowed.
- Read latency: accepted in cycle t -> rvalid at cycle t + READ_LATENCY.
- Grant switch between ports costs zero cycles.
- Simultaneous lock_0/lock_1 in IDLE: only the winner's lock is honoured.
- Lock with req low: tenure counter still runs, so the port cannot be held idle longer than MAX_BURST cycles.

## Test plan
- Reset release, both req reading, addr0 = 5, addr1 = 9, held -> cycle 0: gnt0, mem_address = 5. Cycle 1: gnt1, mem_address = 9. Cycle 1: rvalid0. Cycle 2: rvalid1 (READ_LATENCY = 1).
- Port 1 req+lock held 12 cycles, port 0 req held, MAX_BURST = 8, first grant to port 1 -> port 1 granted 8 consecutive cycles, then gnt0 on cycle 8, ports then alternate.
- Port 0 write, addr 3, be = 0x0000000F, wdata = 0xA5 repeated -> one cycle mem_wren = 1, mem_byteena = 0x0000000F, mem_address = 3. No rvalid0. busy stays 0.
- Port 0 alone, 4 back-to-back reads at addr 0..3, READ_LATENCY = 2 -> gnt0 4 consecutive cycles. rvalid0 high on cycles 2..5, each with matching mem_readdata.
- Read accepted, reset pulsed low for 1 cycle before its return -> no rvalid on either port, busy = 0. The next req is granted normally, with port 0 winning the tie.
- Port 0 lock = 1 for one transfer, then lock = 0 with req = 0 -> state LOCK0 for exactly one cycle, then IDLE. Port 1 req in that locked cycle is not granted; it is granted the next cycle.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin two-master arbiter with bounded burst lock for a single data memory port
// Ports: clk/reset (async active-low); per requester n: req/lock/we/addr/be/wdata in, gnt/rvalid/rdata out;
// memory side: mem_address/mem_byteena/mem_wren/mem_writedata out, mem_readdata in; busy = lock held or read in flight.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 256,
  parameter int BE_W         = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              lock_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [BE_W-1:0]   be_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic              req_1,
  input  logic              lock_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [BE_W-1:0]   be_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteena,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  state_t state, state_nx;
  logic last_winner;
  logic [3:0] burst_cnt, burst_nx;
  logic [READ_LATENCY-1:0] tag_v, tag_id;
  logic xfer, id, we_g, locking, tenure_end;
  // a tie in IDLE goes to the port that did not win last
  assign gnt_0 = state == LOCK0 ? req_0 : state == LOCK1 ? 1'b0 : req_0 & (~req_1 | last_winner);
  assign gnt_1 = state == LOCK1 ? req_1 : state == LOCK0 ? 1'b0 : req_1 & (~req_0 | ~last_winner);
  assign xfer = gnt_0 | gnt_1;
  assign id   = gnt_1;
  assign we_g = id ? we_1 : we_0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      burst_cnt <= burst_nx;
    end
  end
  // the tenure counter runs every locked cycle, so an idle lock still expires
  always_comb begin
    locking    = state == IDLE & xfer & (id ? lock_1 : lock_0);
    tenure_end = (state == LOCK0 ? ~lock_0 : ~lock_1) | burst_cnt == 4'(MAX_BURST - 1);
    state_nx   = locking ? (id ? LOCK1 : LOCK0) : (state != IDLE & tenure_end) ? IDLE : state;
    burst_nx   = locking ? 4'd1 : state != IDLE ? burst_cnt + 4'd1 : burst_cnt;
  end
  always_comb begin
    mem_address   = id ? addr_1 : addr_0;
    mem_writedata = id ? wdata_1 : wdata_0;
    mem_byteena   = xfer ? (id ? be_1 : be_0) : '0;
    mem_wren      = xfer & we_g;
    rvalid_0      = tag_v[READ_LATENCY-1] & ~tag_id[READ_LATENCY-1];
    rvalid_1      = tag_v[READ_LATENCY-1] & tag_id[READ_LATENCY-1];
    rdata_0       = mem_readdata;
    rdata_1       = mem_readdata;
    busy          = state != IDLE | (|tag_v);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_winner <= 1'b1;
      tag_v       <= '0;
      tag_id      <= '0;
    end else begin
      if (xfer) last_winner <= id;
      tag_v[0]  <= xfer & ~we_g;
      tag_id[0] <= id;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed vector bench for dmem_port_arbiter at READ_LATENCY 1 and 2
module tb_dmem_port_arbiter;
  localparam int AW = 14, DW = 256, BW = 32;
  localparam logic [DW-1:0] W0 = {32{8'hA5}};
  localparam logic [DW-1:0] W1 = {32{8'h5A}};
  localparam logic [BW-1:0] B1 = 32'hFFFF0000;
  typedef struct {
    int r0, l0, w0, a0, b0, r1, l1, w1, a1;
    int eg0, eg1, erv0, erv1, ewr, ebusy, ea;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0;
  logic req_0, lock_0, we_0, req_1, lock_1, we_1;
  logic [AW-1:0] addr_0, addr_1;
  logic [BW-1:0] be_0, be_1;
  logic [DW-1:0] wdata_0, wdata_1;
  logic gnt0 [2], gnt1 [2], rv0 [2], rv1 [2], wren [2], busy [2];
  logic [AW-1:0] maddr [2];
  logic [BW-1:0] mbe [2];
  logic [DW-1:0] mwd [2], rd0 [2], rd1 [2];
  logic [DW-1:0] mrd_a, mrd_b;
  logic [AW-1:0] a1, b1, b2;
  int checks = 0, errors = 0;
  vec_t tv [24];
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8{18'd0, a}};
  endfunction
  always_ff @(posedge clk) begin
    a1 <= maddr[0];
    b1 <= maddr[1];
    b2 <= b1;
  end
  assign mrd_a = pat(a1);
  assign mrd_b = pat(b2);
  dmem_port_arbiter #(.READ_LATENCY(1), .MAX_BURST(8)) u1 (
    .clk(clk), .reset(reset),
    .req_0(req_0), .lock_0(lock_0), .we_0(we_0), .addr_0(addr_0), .be_0(be_0), .wdata_0(wdata_0),
    .req_1(req_1), .lock_1(lock_1), .we_1(we_1), .addr_1(addr_1), .be_1(be_1), .wdata_1(wdata_1),
    .gnt_0(gnt0[0]), .gnt_1(gnt1[0]), .rvalid_0(rv0[0]), .rvalid_1(rv1[0]), .rdata_0(rd0[0]), .rdata_1(rd1[0]),
    .mem_address(maddr[0]), .mem_byteena(mbe[0]), .mem_wren(wren[0]), .mem_writedata(mwd[0]),
    .mem_readdata(mrd_a), .busy(busy[0]));
  dmem_port_arbiter #(.READ_LATENCY(2), .MAX_BURST(8)) u2 (
    .clk(clk), .reset(reset),
    .req_0(req_0), .lock_0(lock_0), .we_0(we_0), .addr_0(addr_0), .be_0(be_0), .wdata_0(wdata_0),
    .req_1(req_1), .lock_1(lock_1), .we_1(we_1), .addr_1(addr_1), .be_1(be_1), .wdata_1(wdata_1),
    .gnt_0(gnt0[1]), .gnt_1(gnt1[1]), .rvalid_0(rv0[1]), .rvalid_1(rv1[1]), .rdata_0(rd0[1]), .rdata_1(rd1[1]),
    .mem_address(maddr[1]), .mem_byteena(mbe[1]), .mem_wren(wren[1]), .mem_writedata(mwd[1]),
    .mem_readdata(mrd_b), .busy(busy[1]));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    req_0  = v.r0[0];
    lock_0 = v.l0[0];
    we_0   = v.w0[0];
    addr_0 = v.a0[AW-1:0];
    be_0   = v.b0[BW-1:0];
    req_1  = v.r1[0];
    lock_1 = v.l1[0];
    we_1   = v.w1[0];
    addr_1 = v.a1[AW-1:0];
  endtask
  initial begin
    logic [BW-1:0] ebe;
    tv[0]  = '{1,0,0,5,0, 1,0,0,9, 1,0,0,0,0,0,5};
    tv[1]  = '{1,0,0,5,0, 1,0,0,9, 0,1,1,0,0,1,9};
    tv[2]  = '{0,0,0,5,0, 0,0,0,9, 0,0,0,1,0,1,5};
    tv[3]  = '{0,0,0,5,0, 0,0,0,9, 0,0,0,0,0,0,5};
    tv[4]  = '{1,0,0,1,0, 0,0,0,9, 1,0,0,0,0,0,1};
    tv[5]  = '{1,0,0,2,0, 1,1,0,7, 0,1,1,0,0,1,7};
    for (int i = 6; i <= 12; i++) tv[i] = '{1,0,0,2,0, 1,1,0,7, 0,1,0,1,0,1,7};
    tv[13] = '{1,0,0,2,0, 1,1,0,7, 1,0,0,1,0,1,2};
    tv[14] = '{1,0,0,2,0, 1,0,0,7, 0,1,1,0,0,1,7};
    tv[15] = '{0,0,0,2,0, 0,0,0,7, 0,0,0,1,0,1,2};
    tv[16] = '{0,0,0,2,0, 0,0,0,7, 0,0,0,0,0,0,2};
    tv[17] = '{1,1,1,4,32'hFF, 0,0,0,8, 1,0,0,0,1,0,4};
    tv[18] = '{0,0,0,4,32'hFF, 1,0,0,8, 0,0,0,0,0,1,4};
    tv[19] = '{0,0,0,4,0, 1,0,0,8, 0,1,0,0,0,0,8};
    tv[20] = '{0,0,0,4,0, 0,0,0,8, 0,0,0,1,0,1,4};
    tv[21] = '{0,0,0,4,0, 0,0,0,8, 0,0,0,0,0,0,4};
    tv[22] = '{1,0,1,3,32'h0F, 0,0,0,8, 1,0,0,0,1,0,3};
    tv[23] = '{0,0,0,3,0, 0,0,0,8, 0,0,0,0,0,0,3};
    req_0 = 0; lock_0 = 0; we_0 = 0; addr_0 = '0; be_0 = '0; wdata_0 = W0;
    req_1 = 0; lock_1 = 0; we_1 = 0; addr_1 = '0; be_1 = B1; wdata_1 = W1;
    repeat (2) @(posedge clk);
    #1 req_0 = 1;
    @(negedge clk);
    chk("rst gnt0", int'(gnt0[0]), 1);
    chk("rst gnt1", int'(gnt1[0]), 0);
    chk("rst rvalid0", int'(rv0[0]), 0);
    chk("rst busy", int'(busy[0]), 0);
    chk("rst wren", int'(wren[0]), 0);
    req_0 = 0;
    #1 chk("rst gnt0 low", int'(gnt0[0]), 0);
    chk("rst byteena", int'(mbe[0]), 0);
    @(posedge clk);
    #1 reset = 1;
    for (int i = 0; i < 24; i++) begin
      drive(tv[i]);
      @(negedge clk);
      ebe = tv[i].eg0 != 0 ? tv[i].b0[BW-1:0] : tv[i].eg1 != 0 ? B1 : '0;
      chk($sformatf("row%0d gnt0", i), int'(gnt0[0]), tv[i].eg0);
      chk($sformatf("row%0d gnt1", i), int'(gnt1[0]), tv[i].eg1);
      chk($sformatf("row%0d rvalid0", i), int'(rv0[0]), tv[i].erv0);
      chk($sformatf("row%0d rvalid1", i), int'(rv1[0]), tv[i].erv1);
      chk($sformatf("row%0d wren", i), int'(wren[0]), tv[i].ewr);
      chk($sformatf("row%0d busy", i), int'(busy[0]), tv[i].ebusy);
      chk($sformatf("row%0d addr", i), int'(maddr[0]), tv[i].ea);
      chkw($sformatf("row%0d byteena", i), DW'(mbe[0]), DW'(ebe));
      chkw($sformatf("row%0d wdata", i), mwd[0], tv[i].eg1 != 0 ? W1 : W0);
      chk($sformatf("row%0d gnt0 lat2", i), int'(gnt0[1]), tv[i].eg0);
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < 7; c++) begin
      req_0 = c < 4; lock_0 = 0; we_0 = 0; addr_0 = AW'(c); be_0 = '0;
      req_1 = 0; lock_1 = 0;
      @(negedge clk);
      if (c < 4) chk($sformatf("lat2 c%0d gnt0", c), int'(gnt0[1]), 1);
      chk($sformatf("lat2 c%0d rvalid0", c), int'(rv0[1]), (c >= 2 && c <= 5) ? 1 : 0);
      chk($sformatf("lat2 c%0d rvalid1", c), int'(rv1[1]), 0);
      if (c >= 2 && c <= 5) chkw($sformatf("lat2 c%0d rdata0", c), rd0[1], pat(AW'(c - 2)));
      @(posedge clk);
      #1;
    end
    req_0 = 1; addr_0 = 14'd6;
    @(negedge clk);
    chk("rstmid gnt0", int'(gnt0[0]), 1);
    @(posedge clk);
    #1 reset = 0; req_0 = 0;
    @(negedge clk);
    chk("rstmid rvalid0 l1", int'(rv0[0]), 0);
    chk("rstmid busy l1", int'(busy[0]), 0);
    chk("rstmid busy l2", int'(busy[1]), 0);
    reset = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstmid rvalid0 l2", int'(rv0[1]), 0);
    chk("rstmid rvalid1 l2", int'(rv1[1]), 0);
    chk("rstmid rvalid0 l1 after", int'(rv0[0]), 0);
    chk("rstmid busy after", int'(busy[1]), 0);
    @(posedge clk);
    #1 req_0 = 1; req_1 = 1; addr_0 = 14'd1; addr_1 = 14'd2;
    @(negedge clk);
    chk("rstmid tie gnt0", int'(gnt0[0]), 1);
    chk("rstmid tie gnt1", int'(gnt1[0]), 0);
    chk("rstmid tie addr", int'(maddr[0]), 1);
    @(posedge clk);
    #1 req_0 = 0; req_1 = 0;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
